// File: rtl/cache_stats_monitor.sv
// cache_stats_monitor: counts hits/misses over a fixed access run and computes the hit rate in percent
module cache_stats_monitor #(
  parameter int TOTAL_ACCESSES = 8192,
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             access_valid,
  input  logic             hit,
  input  logic             clear,
  output logic [CNT_W-1:0] access_count,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic             busy,
  output logic             done,
  output logic             rate_valid,
  output logic [6:0]       hit_rate_pct
);
  localparam int DIV_W = CNT_W + 7;
  localparam int IT_W = $clog2(DIV_W + 1);
  localparam logic [CNT_W+1:0] DIVISOR = (CNT_W+2)'(TOTAL_ACCESSES);
  typedef enum logic [1:0] {COUNT, DIVIDE, DONE} state_t;
  state_t state, state_nx;
  logic [DIV_W-1:0] dividend;
  logic [CNT_W:0] rem;
  logic [CNT_W+1:0] rem_sh;
  logic [IT_W-1:0] iter;
  logic [CNT_W-1:0] hit_nx;
  logic last_acc, last_iter, rem_ge;
  assign last_acc = access_valid && access_count == CNT_W'(TOTAL_ACCESSES - 1);
  assign last_iter = iter == IT_W'(DIV_W - 1);
  assign hit_nx = hit_count + CNT_W'(hit);
  assign rem_sh = {rem, dividend[DIV_W-1]};
  assign rem_ge = rem_sh >= DIVISOR;
  // state register
  always_ff @(posedge clk)
    if (!rst_n) state <= COUNT;
    else state <= state_nx;
  // next state: clear restarts the run from any state
  always_comb
    state_nx = clear ? COUNT :
               state == COUNT ? (last_acc ? DIVIDE : COUNT) :
               state == DIVIDE ? (last_iter ? DONE : DIVIDE) : DONE;
  // status outputs decoded from state
  always_comb begin
    busy = state == DIVIDE;
    done = state == DONE;
    rate_valid = state == DONE;
  end
  // access counters; frozen outside COUNT
  always_ff @(posedge clk)
    if (!rst_n || clear) begin
      access_count <= '0;
      hit_count <= '0;
      miss_count <= '0;
    end else if (state == COUNT && access_valid) begin
      access_count <= access_count + 1'b1;
      hit_count <= hit_nx;
      miss_count <= miss_count + CNT_W'(!hit);
    end
  // restoring divider; quotient bits shift into the dividend LSB as it empties
  always_ff @(posedge clk)
    if (!rst_n || clear) begin
      dividend <= '0;
      rem <= '0;
      iter <= '0;
      hit_rate_pct <= '0;
    end else if (state == COUNT && last_acc) begin
      dividend <= DIV_W'(hit_nx) * DIV_W'(100);
      rem <= '0;
      iter <= '0;
    end else if (state == DIVIDE) begin
      dividend <= {dividend[DIV_W-2:0], rem_ge};
      rem <= rem_ge ? (CNT_W+1)'(rem_sh - DIVISOR) : rem_sh[CNT_W:0];
      iter <= iter + 1'b1;
      if (last_iter) hit_rate_pct <= {dividend[5:0], rem_ge};
    end
endmodule

// File: tb/tb_cache_stats_monitor.sv
// tb_cache_stats_monitor: random stimulus against a count/divide reference model for two configurations
module tb_cache_stats_monitor;
  localparam int TA = 8192, CA = 14, DA = 21;
  localparam int TB = 10, CB = 4, DB = 11;
  logic clk = 0;
  always #5 clk = ~clk;
  logic [1:0] rn, cl, av, ht;
  logic [CA-1:0] a_acc, a_hit, a_miss;
  logic [CB-1:0] b_acc, b_hit, b_miss;
  logic a_busy, a_done, a_rv, b_busy, b_done, b_rv;
  logic [6:0] a_pct, b_pct;
  int m_acc[2], m_hit[2], m_ph[2], m_cy[2], m_rate[2];
  int tot[2] = '{TA, TB};
  int divw[2] = '{DA, DB};
  int checks = 0, failures = 0;

  cache_stats_monitor #(.TOTAL_ACCESSES(TA), .CNT_W(CA)) dut_a (
    .clk(clk), .rst_n(rn[0]), .access_valid(av[0]), .hit(ht[0]), .clear(cl[0]),
    .access_count(a_acc), .hit_count(a_hit), .miss_count(a_miss),
    .busy(a_busy), .done(a_done), .rate_valid(a_rv), .hit_rate_pct(a_pct));

  cache_stats_monitor #(.TOTAL_ACCESSES(TB), .CNT_W(CB)) dut_b (
    .clk(clk), .rst_n(rn[1]), .access_valid(av[1]), .hit(ht[1]), .clear(cl[1]),
    .access_count(b_acc), .hit_count(b_hit), .miss_count(b_miss),
    .busy(b_busy), .done(b_done), .rate_valid(b_rv), .hit_rate_pct(b_pct));

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    if (obs !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference: count until the run length is reached, then the result appears DIV_W edges later
  task automatic upd(input int d);
    if (!rn[d] || cl[d]) begin
      m_acc[d] = 0; m_hit[d] = 0; m_ph[d] = 0; m_cy[d] = 0; m_rate[d] = 0;
    end else if (m_ph[d] == 0) begin
      if (av[d]) begin
        m_acc[d]++;
        m_hit[d] += int'(ht[d]);
        if (m_acc[d] == tot[d]) begin m_ph[d] = 1; m_cy[d] = 0; end
      end
    end else if (m_ph[d] == 1) begin
      m_cy[d]++;
      if (m_cy[d] == divw[d]) begin m_ph[d] = 2; m_rate[d] = m_hit[d] * 100 / tot[d]; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    upd(0);
    upd(1);
    #1;
    chk("a_acc", a_acc, m_acc[0]);
    chk("a_hit", a_hit, m_hit[0]);
    chk("a_miss", a_miss, m_acc[0] - m_hit[0]);
    chk("a_busy", a_busy, int'(m_ph[0] == 1));
    chk("a_done", a_done, int'(m_ph[0] == 2));
    chk("a_rv", a_rv, int'(m_ph[0] == 2));
    chk("a_pct", a_pct, m_rate[0]);
    chk("b_acc", b_acc, m_acc[1]);
    chk("b_hit", b_hit, m_hit[1]);
    chk("b_miss", b_miss, m_acc[1] - m_hit[1]);
    chk("b_busy", b_busy, int'(m_ph[1] == 1));
    chk("b_done", b_done, int'(m_ph[1] == 2));
    chk("b_rv", b_rv, int'(m_ph[1] == 2));
    chk("b_pct", b_pct, m_rate[1]);
  endtask

  function automatic bit pat_a(input int mode, input int idx);
    return mode == 0 ? 1'b1 : mode == 1 ? (idx % 4 == 0) : mode == 2 ? (idx != TA - 1) : (idx == 0);
  endfunction

  // one full run on the default-size instance with random idle gaps
  task automatic run_a(input int mode, input int exp_pct);
    for (int i = 0; i < 4 * TA && m_ph[0] == 0; i++) begin
      av[0] = $urandom_range(7) != 0;
      ht[0] = av[0] ? pat_a(mode, m_acc[0]) : 1'($urandom);
      tick();
    end
    chk("a_enter_div", a_busy, 1);
    for (int i = 0; i < DA + 2; i++) begin
      av[0] = 1'($urandom); ht[0] = 1'($urandom);
      tick();
    end
    chk("a_rate", a_pct, exp_pct);
    chk("a_rate_valid", a_rv, 1);
    chk("a_frozen", a_acc, TA);
    av[0] = 0; cl[0] = 1;
    tick();
    cl[0] = 0;
  endtask

  // drive the small instance until it enters DIVIDE; nh<0 gives random hits
  task automatic fill_b(input int nh);
    for (int i = 0; i < 200 && m_ph[1] == 0; i++) begin
      av[1] = $urandom_range(3) != 0;
      ht[1] = !av[1] ? 1'($urandom) : nh < 0 ? 1'($urandom) : m_acc[1] < nh;
      tick();
    end
    chk("b_enter_div", b_busy, 1);
    av[1] = 0;
  endtask

  initial begin
    rn = 2'b00; cl = 0; av = 0; ht = 0;
    for (int i = 0; i < 2; i++) begin
      av = ~av; ht = 2'b11;
      tick();
    end
    chk("rst_a_acc", a_acc, 0);
    chk("rst_b_pct", b_pct, 0);
    rn = 2'b11;
    av[0] = 1; ht[0] = 1; tick();
    ht[0] = 0; tick();
    ht[0] = 1; tick();
    av[0] = 0;
    chk("t1_acc", a_acc, 3);
    chk("t1_hit", a_hit, 2);
    chk("t1_miss", a_miss, 1);
    cl[0] = 1; tick(); cl[0] = 0;
    run_a(0, 100);
    run_a(1, 25);
    run_a(2, 99);
    run_a(3, 0);

    fill_b(7);
    begin
      int n = 0;
      while (b_busy && n < 50) begin
        av[1] = 1'($urandom); ht[1] = 1;
        tick();
        n++;
      end
      chk("b_div_len", n, DB);
    end
    chk("b_pct70", b_pct, 70);
    av[1] = 1; ht[1] = 1;
    repeat (3) tick();
    chk("b_done_acc", b_acc, 10);
    av[1] = 0; cl[1] = 1; tick(); cl[1] = 0;

    av[1] = 0; ht[1] = 1;
    repeat (3) tick();
    chk("b_hit_novalid", b_hit, 0);

    fill_b(-1);
    repeat (4) tick();
    cl[1] = 1; av[1] = 1; tick(); cl[1] = 0; av[1] = 0;
    chk("b_abort_acc", b_acc, 0);
    chk("b_abort_busy", b_busy, 0);
    chk("b_abort_rv", b_rv, 0);
    fill_b(3);
    repeat (DB + 1) tick();
    chk("b_fresh_pct", b_pct, 30);

    cl[1] = 1; tick(); cl[1] = 0;
    av[1] = 1; ht[1] = 1;
    repeat (5) tick();
    rn[1] = 0; cl[1] = 1; tick();
    rn[1] = 1; cl[1] = 0; av[1] = 0;
    chk("b_rst_acc", b_acc, 0);
    chk("b_rst_hit", b_hit, 0);

    fill_b(-1);
    repeat (DB + 1) tick();
    chk("b_done_pre", b_done, 1);
    cl[1] = 1; tick(); cl[1] = 0;
    chk("b_clr_done", b_done, 0);
    chk("b_clr_rv", b_rv, 0);

    for (int i = 0; i < 1500; i++) begin
      av[1] = $urandom_range(3) != 0;
      ht[1] = 1'($urandom);
      cl[1] = $urandom_range(49) == 0;
      rn[1] = $urandom_range(79) != 0;
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
